// File: rtl/nn_pkg.sv
// Shared types and constants for the network-memory loader and its byte packer.
package nn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_LOAD   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } loader_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  // The header is a single little-endian word; N occupies the whole word.
  localparam int HDR_N_LSB = 0;
  localparam int HDR_N_W   = 32;

  function automatic logic [31:0] hdr_word_count(input logic [31:0] hdr);
    return hdr[HDR_N_LSB +: HDR_N_W];
  endfunction

endpackage

// File: rtl/nn_byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream; word_valid_o pulses
// one cycle after the byte that completes a word, word_data_o holds until the next word.
module nn_byte_packer
  import nn_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_last_o,
  output logic        word_valid_o,
  output logic [31:0] word_data_o
);

  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [31:0]           shift_q, shift_d;
  logic [31:0]           word_q, word_d;
  logic                  valid_q, valid_d;

  // Combinational: the byte being accepted this cycle is the last of a word.
  assign word_last_o = byte_valid_i && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      idx_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      shift_d = {byte_i, shift_q[31:8]};
      idx_d   = idx_q + 1'b1;
      if (word_last_o) begin
        word_d  = shift_d;
        valid_d = 1'b1;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_valid_o = valid_q;
  assign word_data_o  = word_q;

endmodule

// File: rtl/nn_mem_loader.sv
// Fills the network BRAM from a byte stream: header word N, then N payload words.
// Define NN_MEM_LOADER_CHECKSUM_EN to require a trailing XOR-of-payload word.
module nn_mem_loader
  import nn_pkg::*;
#(
  parameter int ADDR_LEN = 2**16,
  parameter int DATA_LEN = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic [7:0]                  rx_data_i,
  input  logic                        rx_valid_i,
  output logic                        rx_ready_o,
  output logic                        wr_ena_o,
  output logic [$clog2(ADDR_LEN)-1:0] wr_addr_o,
  output logic [DATA_LEN-1:0]         wr_data_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [31:0]                 word_count_o
);

  localparam int AW = $clog2(ADDR_LEN);

`ifdef NN_MEM_LOADER_CHECKSUM_EN
  localparam loader_state_e LOAD_EXIT = ST_CHECK;
`else
  localparam loader_state_e LOAD_EXIT = ST_DONE;
`endif

  loader_state_e        state_q, state_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 wr_ena_q, wr_ena_d;
  logic                 last_q, last_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [DATA_LEN-1:0]  wr_data_q, wr_data_d;
  logic [31:0]          word_count_q, word_count_d;
`ifdef NN_MEM_LOADER_CHECKSUM_EN
  logic [31:0]          xor_q, xor_d;
`endif

  logic                 rx_hs;
  logic                 pk_clear;
  logic                 pk_last;
  logic                 pk_valid;
  logic [31:0]          pk_word;
  logic [31:0]          hdr_n;

  // A byte moves only when rx_valid_i and rx_ready_o are both high on a rising
  // edge; the source must hold rx_data_i stable while rx_valid_i waits for ready.
  assign rx_hs = rx_valid_i && rx_ready_q;

  nn_byte_packer u_packer (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (pk_clear),
    .byte_valid_i (rx_hs),
    .byte_i       (rx_data_i),
    .word_last_o  (pk_last),
    .word_valid_o (pk_valid),
    .word_data_o  (pk_word)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    word_count_d = word_count_q;
    done_d       = done_q;
    err_d        = err_q;
    last_d       = last_q;
    wr_ena_d     = 1'b0;
    pk_clear     = 1'b0;
    hdr_n        = '0;
`ifdef NN_MEM_LOADER_CHECKSUM_EN
    xor_d        = xor_q;
`endif

    if (wr_ena_q) begin
      wr_data_d = pk_word;
`ifdef NN_MEM_LOADER_CHECKSUM_EN
      xor_d     = xor_q ^ pk_word;
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          done_d   = 1'b0;
          err_d    = 1'b0;
          addr_d   = '0;
          last_d   = 1'b0;
          pk_clear = 1'b1;
`ifdef NN_MEM_LOADER_CHECKSUM_EN
          xor_d    = '0;
`endif
          state_d  = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (pk_valid) begin
          hdr_n        = hdr_word_count(pk_word);
          word_count_d = hdr_n;
          if (hdr_n == 32'd0)
            state_d = LOAD_EXIT;
          else if (hdr_n > 32'(ADDR_LEN))
            state_d = ST_ERROR;
          else
            state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The address is latched for the write cycle that follows the 4th byte.
        if (pk_last) begin
          wr_ena_d  = 1'b1;
          wr_addr_d = addr_q;
          addr_d    = addr_q + AW'(1);
          last_d    = ((32'(addr_q) + 32'd1) == word_count_q);
        end
        if (wr_ena_q && last_q)
          state_d = LOAD_EXIT;
      end
`ifdef NN_MEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (pk_valid)
          state_d = (pk_word == xor_q) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d     = (state_d == ST_HEADER) || (state_d == ST_LOAD) || (state_d == ST_CHECK);
    rx_ready_d = busy_d;
    if (state_d == ST_DONE)
      done_d = 1'b1;
    if (state_d == ST_ERROR)
      err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      rx_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wr_ena_q     <= 1'b0;
      last_q       <= 1'b0;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      word_count_q <= '0;
`ifdef NN_MEM_LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= rx_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      wr_ena_q     <= wr_ena_d;
      last_q       <= last_d;
      addr_q       <= addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      word_count_q <= word_count_d;
`ifdef NN_MEM_LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign rx_ready_o   = rx_ready_q;
  assign wr_ena_o     = wr_ena_q;
  assign wr_addr_o    = wr_addr_q;
  // The packer's word register holds until the next word completes, which may be
  // a header or trailer; the hold register keeps the bus at the last written word.
  assign wr_data_o    = wr_ena_q ? pk_word : wr_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_count_o = word_count_q;

endmodule

// File: doc/nn_mem_loader.md
Name: nn_mem_loader

Overview:
- Writer side of the network BRAM. It fills the memory image that the inference engine later reads: layer neuron counts, neuron values and weights.
- Accepts a byte stream over a valid/ready handshake (e.g. from a UART receiver) and assembles little-endian 32-bit words.
- Drives the BRAM write port at sequential addresses from 0.
- Signals done_o so the inference FSM can be released from reset or started.

Parameters:
- ADDR_LEN, 2**16: BRAM depth in words; address width is $clog2(ADDR_LEN).
- DATA_LEN, 32: BRAM word width. Fixed at 32; byte assembly assumes 4 bytes per word.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset. Synchronous, active-high, single clock domain.
- start_i  in  1  one-cycle pulse that arms a load. Ignored while busy_o=1.
- rx_data_i  in  8  stream byte.
- rx_valid_i  in  1  byte valid.
- rx_ready_o  out  1  byte accepted when rx_valid_i & rx_ready_o.
- wr_ena_o  out  1  BRAM write strobe, one cycle per word.
- wr_addr_o  out  $clog2(ADDR_LEN)  BRAM write address.
- wr_data_o  out  32  BRAM write data.
- busy_o  out  1  load in progress.
- done_o  out  1  last load completed successfully (sticky).
- err_o  out  1  last load aborted (sticky).
- word_count_o  out  32  payload word count N from the header.

Behaviour:
- Reset values: every output is 0, state is IDLE, byte index is 0, address counter is 0, assembly shift register is 0.
- States:
  - IDLE
    - rx_ready_o=0.
    - start_i clears done_o and err_o, zeroes the address and byte index, then moves to HEADER.
  - HEADER
    - rx_ready_o=1.
    - Collect 4 bytes, least-significant byte first, into N. N is registered to word_count_o.
    - N == 0: go to DONE with no writes.
    - N > ADDR_LEN: go to ERROR.
    - Otherwise go to LOAD.
  - LOAD
    - rx_ready_o=1.
    - Each 4th accepted byte completes a word. On the next cycle: wr_ena_o=1, wr_data_o={b3,b2,b1,b0}, wr_addr_o=current address. The address then increments.
    - Write latency: exactly 1 cycle after the 4th handshake. wr_ena_o is high for exactly one cycle per word.
    - When word N-1 has been issued, go to DONE (or CHECK when the feature is enabled).
  - DONE: done_o=1, busy_o=0, then return to IDLE in the same transition.
  - ERROR: err_o=1, busy_o=0, rx_ready_o=0, then return to IDLE.
- busy_o=1 in HEADER, LOAD and CHECK.
- Bytes with rx_valid_i=0 are not counted. Gaps of any length are allowed mid-word.
- Back-to-back bytes on consecutive cycles must be sustained with no stall; rx_ready_o never drops inside LOAD.
- Address wrap: it cannot occur, because N ≤ ADDR_LEN is enforced. N == ADDR_LEN writes 0..ADDR_LEN-1.
- wr_addr_o and wr_data_o hold their last values when wr_ena_o=0.
- start_i is ignored while busy. start_i arriving in the same cycle as the DONE transition is honoured on the following IDLE cycle only if re-pulsed.
- reset_i mid-load: a partial word is discarded, no write is issued, and outputs return to reset values. BRAM contents already written are left as-is.

Optional Feature:
- Macro: NN_MEM_LOADER_CHECKSUM_EN.
- When defined:
  - A running XOR of all N payload words is kept.
  - After LOAD, the CHECK state accepts one more 4-byte word (no BRAM write).
  - If that word equals the running XOR, go to DONE; otherwise go to ERROR.
  - For N == 0, CHECK expects 32'h0000_0000.
- When undefined: the CHECK state, the XOR register and the trailer word do not exist.

Decomposition:
- Shared package nn_pkg holds:
  - the loader state typedef (IDLE, HEADER, LOAD, CHECK, DONE, ERROR), 3-bit;
  - localparam BYTES_PER_WORD = 4;
  - the header field layout constant.
- One sub-module, nn_byte_packer: byte index counter plus 32-bit shift register. It emits word_valid and word_data one cycle after the 4th byte, and has a clear input. The FSM, address counter, N comparison and checksum stay in nn_mem_loader.

Test Plan:
1. start; bytes 02 00 00 00, 78 56 34 12, EF BE AD DE, contiguous -> writes addr0=32'h12345678, addr1=32'hDEADBEEF; word_count_o=2; done_o=1; err_o=0.
2. Header N=0 -> no wr_ena_o pulse; done_o=1 within 2 cycles of the 4th header byte.
3. Header N=ADDR_LEN+1 (parameter overridden, ADDR_LEN=16, header 11 00 00 00) -> err_o=1, rx_ready_o=0, no writes.
4. N=1 with random rx_valid_i gaps (0–5 cycles between bytes) -> a single write of the correct word; wr_ena_o exactly 1 cycle, one cycle after the last handshake.
5. reset_i asserted after 2 payload bytes of word 0 -> no write; all outputs 0. A subsequent start loads a fresh image correctly.
6. Checksum enabled, N=2 words A5A5A5A5 and 0F0F0F0F:
   - trailer AAAAAAAA -> done_o=1;
   - trailer 00000000 -> err_o=1; both payload words are still written.
